// File: rtl/constants_pkg.sv
// Shared opcode type and latched control bundle
// for the ALU / register-file datapath.
package constants_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;

  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_DIN = 1'b1;

  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1,
    ADD       = 2'd2,
    SUB       = 2'd3
  } ALUOp;

  typedef struct packed {
    logic [REG_AW-1:0] rd0_addr;
    logic [REG_AW-1:0] rd1_addr;
    logic [REG_AW-1:0] wr_addr;
    logic              rd0_en;
    logic              rd1_en;
    logic              wr_en;
    logic              subtract;
    logic              sel;
  } ctrl_t;

endpackage

// File: rtl/alu.sv
// Add/subtract leaf cell: result = a + b + cin,
// carry of the MSB on cout.
module alu #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] result,
  output logic         cout
);

  assign {cout, result} = {1'b0, a} + {1'b0, b}
                        + {{W{1'b0}}, cin};

endmodule

// File: rtl/mux2to1.sv
// Two-input word mux leaf cell.
module mux2to1 #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/register_file.sv
// 16-entry register file: two gated combinational
// read ports, one synchronous write port.
module register_file
  import constants_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rd0_addr_i,
  input  logic              rd0_en_i,
  output logic [W-1:0]      rd0_data_o,
  input  logic [REG_AW-1:0] rd1_addr_i,
  input  logic              rd1_en_i,
  output logic [W-1:0]      rd1_data_o,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic              wr_en_i,
  input  logic [W-1:0]      wr_data_i
);

  logic [W-1:0] regs_q [NUM_REGS];

  // Reset wins over a write committing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd0_data_o = rd0_en_i ? regs_q[rd0_addr_i] : '0;
  assign rd1_data_o = rd1_en_i ? regs_q[rd1_addr_i] : '0;

endmodule

// File: rtl/alu_regfile_datapath.sv
// Datapath core: op-decoding control register,
// register file, add/sub ALU and write-back mux.
module alu_regfile_datapath
  import constants_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_AW-1:0]    addr_a,
  input  logic [REG_AW-1:0]    addr_b,
  input  logic [REG_AW-1:0]    addr_r,
  input  logic [DATA_BITS-1:0] data_in,
  input  ALUOp                 op,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 carry_out
);

  ctrl_t ctrl_q, ctrl_d;

  logic [DATA_BITS-1:0] rd0_data;
  logic [DATA_BITS-1:0] rd1_data;
  logic [DATA_BITS-1:0] b_op;
  logic [DATA_BITS-1:0] alu_res;
  logic [DATA_BITS-1:0] wr_data;

  // Fields an op does not mention keep their last value.
  always_comb begin
    ctrl_d = ctrl_q;
    unique case (op)
      REG_READ: begin
        ctrl_d.rd0_addr = addr_a;
        ctrl_d.rd0_en   = 1'b1;
        ctrl_d.rd1_en   = 1'b0;
        ctrl_d.wr_en    = 1'b0;
        ctrl_d.sel      = SEL_ALU;
      end
      REG_WRITE: begin
        ctrl_d.wr_addr = addr_a;
        ctrl_d.wr_en   = 1'b1;
        ctrl_d.rd0_en  = 1'b0;
        ctrl_d.rd1_en  = 1'b0;
        ctrl_d.sel     = SEL_DIN;
      end
      ADD, SUB: begin
        ctrl_d.rd0_addr = addr_a;
        ctrl_d.rd1_addr = addr_b;
        ctrl_d.wr_addr  = addr_r;
        ctrl_d.rd0_en   = 1'b1;
        ctrl_d.rd1_en   = 1'b1;
        ctrl_d.wr_en    = 1'b1;
        ctrl_d.subtract = (op == SUB);
        ctrl_d.sel      = SEL_ALU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  register_file #(
    .W (DATA_BITS)
  ) u_rf (
    .clk        (clk),
    .reset      (reset),
    .rd0_addr_i (ctrl_q.rd0_addr),
    .rd0_en_i   (ctrl_q.rd0_en),
    .rd0_data_o (rd0_data),
    .rd1_addr_i (ctrl_q.rd1_addr),
    .rd1_en_i   (ctrl_q.rd1_en),
    .rd1_data_o (rd1_data),
    .wr_addr_i  (ctrl_q.wr_addr),
    .wr_en_i    (ctrl_q.wr_en),
    .wr_data_i  (wr_data)
  );

  // Two's-complement subtract: invert B, carry in 1.
  assign b_op = ctrl_q.subtract ? ~rd1_data : rd1_data;

  alu #(
    .W (DATA_BITS)
  ) u_alu (
    .a      (rd0_data),
    .b      (b_op),
    .cin    (ctrl_q.subtract),
    .result (alu_res),
    .cout   (carry_out)
  );

  mux2to1 #(
    .W (DATA_BITS)
  ) u_wb (
    .sel (ctrl_q.sel),
    .in0 (alu_res),
    .in1 (data_in),
    .out (wr_data)
  );

  assign data_out = rd0_data;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Directed bench for alu_regfile_datapath with an
// op-level reference model checked every cycle.
module tb_alu_regfile_datapath;
  import constants_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr_a, addr_b, addr_r;
  logic [7:0] data_in;
  ALUOp       op;
  logic [7:0] data_out;
  logic       carry_out;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  alu_regfile_datapath #(
    .DATA_BITS (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .addr_r    (addr_r),
    .data_in   (data_in),
    .op        (op),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  // Model: register values plus the op sampled last edge.
  typedef enum {M_IDLE, M_RD, M_WR, M_ADD, M_SUB} mop_e;
  int   mreg [16];
  mop_e m_op = M_IDLE;
  int   m_a, m_b, m_r;

  always @(posedge clk) begin
    if (reset) begin
      foreach (mreg[i]) mreg[i] = 0;
      m_op = M_IDLE;
    end else begin
      case (m_op)
        M_WR:  mreg[m_a] = int'(data_in);
        M_ADD: mreg[m_r] = (mreg[m_a] + mreg[m_b]) % 256;
        M_SUB: mreg[m_r] = (mreg[m_a] - mreg[m_b] + 256) % 256;
        default: ;
      endcase
      case (op)
        REG_READ:  m_op = M_RD;
        REG_WRITE: m_op = M_WR;
        ADD:       m_op = M_ADD;
        default:   m_op = M_SUB;
      endcase
      m_a = int'(addr_a);
      m_b = int'(addr_b);
      m_r = int'(addr_r);
    end
  end

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int exp_d;
      exp_d = (m_op == M_RD || m_op == M_ADD ||
               m_op == M_SUB) ? mreg[m_a] : 0;
      chk("data_out", data_out, 8'(exp_d));
      case (m_op)
        M_IDLE: chk("carry_rst", {7'd0, carry_out}, 8'd0);
        M_ADD:  chk("carry_add", {7'd0, carry_out},
                    8'((mreg[m_a] + mreg[m_b]) > 255));
        M_SUB:  chk("carry_sub", {7'd0, carry_out},
                    8'(mreg[m_a] >= mreg[m_b]));
        default: ;
      endcase
    end
  end

  task automatic issue(ALUOp o, logic [3:0] a,
                       logic [3:0] b = 0,
                       logic [3:0] r = 0,
                       logic [7:0] d = 0);
    op     = o;
    addr_a = a;
    addr_b = b;
    addr_r = r;
    if (o == REG_WRITE) data_in = d;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(logic [3:0] a, logic [7:0] d);
    issue(REG_WRITE, a, 0, 0, d);
    issue(REG_READ, a);
  endtask

  initial begin
    reset   = 1'b1;
    op      = REG_READ;
    addr_a  = 0;
    addr_b  = 0;
    addr_r  = 0;
    data_in = 0;
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst data_out", data_out, 8'h00);
    chk("rst carry", {7'd0, carry_out}, 8'h00);

    for (int i = 0; i < 16; i++) begin
      issue(REG_READ, 4'(i));
      chk("rst reg", data_out, 8'h00);
    end

    issue(REG_WRITE, 3, 0, 0, 8'h2A);
    issue(REG_READ, 3);
    chk("r3 read", data_out, 8'h2A);

    wr(1, 8'hF0);
    wr(2, 8'h20);
    issue(ADD, 1, 2, 4);
    chk("add carry", {7'd0, carry_out}, 8'h01);
    issue(REG_READ, 4);
    chk("r4 sum", data_out, 8'h10);
    chk("model r4", 8'(mreg[4]), 8'h10);
    issue(SUB, 2, 1, 5);
    chk("sub carry", {7'd0, carry_out}, 8'h00);
    issue(REG_READ, 5);
    chk("r5 diff", data_out, 8'h30);

    wr(6, 8'h05);
    issue(ADD, 6, 6, 6);
    issue(REG_READ, 6);
    chk("r6 x1", data_out, 8'h0A);
    wr(6, 8'h05);
    issue(ADD, 6, 6, 6);
    issue(ADD, 6, 6, 6);
    issue(REG_READ, 6);
    chk("r6 x2", data_out, 8'h14);
    chk("model r6", 8'(mreg[6]), 8'h14);

    issue(REG_WRITE, 7, 0, 0, 8'h11);
    issue(ADD, 7, 7, 8);
    issue(REG_READ, 8);
    chk("r8 nohaz", data_out, 8'h22);

    issue(REG_WRITE, 9, 0, 0, 8'h77);
    reset  = 1'b1;
    op     = REG_READ;
    addr_a = 9;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk("rst2 carry", {7'd0, carry_out}, 8'h00);
    chk("model r9", 8'(mreg[9]), 8'h00);
    for (int i = 0; i < 16; i++) begin
      issue(REG_READ, 4'(i));
      chk("rst2 reg", data_out, 8'h00);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
